// File: rtl/floatmul_pipe.sv
// floatmul_pipe: pipelined IEEE-754-style multiplier joining two valid/ready operand streams
module floatmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    busy,
  input  logic                    a_valid,
  input  logic [EXP_W+FRAC_W:0]   a_payload,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [EXP_W+FRAC_W:0]   b_payload,
  output logic                    b_ready,
  output logic                    o_valid,
  output logic [EXP_W+FRAC_W:0]   o_payload,
  output logic [3:0]              o_flags,
  input  logic                    o_ready
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int PW = 2 * FRAC_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E = {3'b000, {EXP_W-1{1'b1}}};
  localparam logic [EW-1:0] MAX_E  = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {FRAC_W-1{1'b0}}};
  logic                sa, sb, sign;
  logic [EXP_W-1:0]    ea, eb;
  logic [FRAC_W-1:0]   fa, fb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0]       prod;
  logic [PW-2:0]       pn;
  logic                hi, g, st, rb, cy, ovf, uf;
  logic [FRAC_W-1:0]   fr, fr_out;
  logic [EW-1:0]       e;
  logic [W-1:0]        inf_v, zero_v;
  logic [W+3:0]        norm, res;
  logic [STAGES-1:0]   v, rdy;
  logic [W+3:0]        d [STAGES];
  logic                r, fire;
  assign {sa, ea, fa} = a_payload;
  assign {sb, eb, fb} = b_payload;
  assign sign   = sa ^ sb;
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_inf  = &ea & ~|fa;
  assign b_inf  = &eb & ~|fb;
  assign a_nan  = &ea & |fa;
  assign b_nan  = &eb & |fb;
  assign inf_v  = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign zero_v = {sign, {W-1{1'b0}}};
  // pn drops the hidden bit after normalising so the product sits in [1,2)
  assign prod   = {{FRAC_W+1{1'b0}}, 1'b1, fa} * {{FRAC_W+1{1'b0}}, 1'b1, fb};
  assign hi     = prod[PW-1];
  assign pn     = hi ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
  assign fr     = pn[2*FRAC_W -: FRAC_W];
  assign g      = pn[FRAC_W];
  assign st     = |pn[FRAC_W-1:0];
  assign rb     = g & (st | fr[0]);
  assign cy     = rb & &fr;
  assign fr_out = fr + {{FRAC_W-1{1'b0}}, rb};
  assign e      = {2'b00, ea} + {2'b00, eb} - BIAS_E + {{EW-1{1'b0}}, hi} + {{EW-1{1'b0}}, cy};
  assign ovf    = ~e[EW-1] & (e >= MAX_E);
  assign uf     = e[EW-1] | ~|e;
  assign norm   = ovf ? {inf_v, 4'b0101} :
                  uf  ? {zero_v, 4'b0011} :
                        {sign, e[EXP_W-1:0], fr_out, 3'b000, g | st};
  assign res    = (a_nan | b_nan)                     ? {QNAN, 4'b0000} :
                  ((a_inf & b_zero) | (b_inf & a_zero)) ? {QNAN, 4'b1000} :
                  (a_inf | b_inf)                     ? {inf_v, 4'b0000} :
                  (a_zero | b_zero)                   ? {zero_v, 4'b0000} : norm;
  always_comb begin
    r   = o_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = ~v[k] | r;
      rdy[k] = r;
    end
  end
  assign fire      = a_valid & b_valid & rdy[0];
  assign a_ready   = b_valid & rdy[0];
  assign b_ready   = a_valid & rdy[0];
  assign busy      = |v;
  assign o_valid   = v[STAGES-1];
  assign o_payload = d[STAGES-1][W+3:4];
  assign o_flags   = d[STAGES-1][3:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      if (rdy[0]) v[0] <= fire;
      if (fire) d[0] <= res;
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) v[k] <= v[k-1];
        if (rdy[k] & v[k-1]) d[k] <= d[k-1];
      end
    end
endmodule

// File: tb/tb_floatmul_pipe.sv
// tb_floatmul_pipe: vector table, join/stall/reset sequences and randomized scoreboard check
module tb_floatmul_pipe;
  logic        clk = 0, rst_n = 0;
  logic        busy, a_valid, a_ready, b_valid, b_ready, o_valid, o_ready;
  logic [31:0] a_payload, b_payload, o_payload;
  logic [3:0]  o_flags;
  always #5 clk = ~clk;

  floatmul_pipe dut (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .a_valid(a_valid), .a_payload(a_payload), .a_ready(a_ready),
    .b_valid(b_valid), .b_payload(b_payload), .b_ready(b_ready),
    .o_valid(o_valid), .o_payload(o_payload), .o_flags(o_flags), .o_ready(o_ready)
  );

  typedef struct packed {
    logic [31:0] a, b, p;
    logic [3:0]  f;
  } vec_t;

  vec_t tbl [15] = '{
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
    '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101},
    '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011},
    '{32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000},
    '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000},
    '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000},
    '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000},
    '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000},
    '{32'hBF800000, 32'hBF800000, 32'h3F800000, 4'b0000},
    '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000},
    '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000},
    '{32'hFF000000, 32'h7F000000, 32'hFF800000, 4'b0101},
    '{32'h7E800000, 32'h40000000, 32'h7F000000, 4'b0000},
    '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000},
    '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011}
  };

  int          vecs = 0, errs = 0, nfire = 0;
  logic [35:0] sb [$];
  logic [35:0] cur_exp, hold_d;
  logic        hold_v = 0, done = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Exact-rational reference: round the integer product by quotient/remainder
  function automatic logic [35:0] model(logic [31:0] a, logic [31:0] b);
    logic s, an, bn, ai, bi, az, bz;
    int ea, eb, e, sh;
    logic [63:0] p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = ea == 255 && a[22:0] != 0;
    bn = eb == 255 && b[22:0] != 0;
    ai = ea == 255 && a[22:0] == 0;
    bi = eb == 255 && b[22:0] == 0;
    az = ea == 0;
    bz = eb == 0;
    if (an || bn) return {32'h7FC00000, 4'b0000};
    if ((ai && bz) || (bi && az)) return {32'h7FC00000, 4'b1000};
    if (ai || bi) return {s, 8'hFF, 23'd0, 4'b0000};
    if (az || bz) return {s, 31'd0, 4'b0000};
    p    = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    e = ea + eb - 150 + sh;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0) return {s, 31'd0, 4'b0011};
    return {s, e[7:0], q[22:0], 3'b000, rem != 0};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] x = $urandom;
    int m = $urandom_range(0, 9);
    if (m == 0) x[30:23] = 8'h00;
    else if (m == 1) x[30:23] = 8'hFF;
    else if (m == 2) x[30:0] = {8'hFF, 23'd0};
    else if (m < 7) x[30:23] = 8'($urandom_range(100, 154));
    return x;
  endfunction

  always @(negedge clk)
    if (rst_n) begin
      if (hold_v) chk("stall_hold", {o_valid, o_payload, o_flags}, {1'b1, hold_d});
      hold_v = o_valid & ~o_ready;
      hold_d = {o_payload, o_flags};
      if (a_valid && b_valid && a_ready) begin
        sb.push_back(cur_exp);
        nfire++;
      end
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_output: got %h with nothing pending", {o_payload, o_flags});
        end else chk("result", {o_payload, o_flags}, sb.pop_front());
      end
    end else hold_v = 0;

  task automatic send(logic [31:0] a, logic [31:0] b, logic [35:0] e);
    int t = 0;
    a_payload = a;
    b_payload = b;
    cur_exp   = e;
    a_valid   = 1;
    b_valid   = 1;
    @(negedge clk);
    while (!a_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!a_ready) begin
      vecs++;
      errs++;
      $display("FAIL send_timeout: got a_ready 0 after %0d cycles, expected 1", t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0;
    b_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    int lat, n0, t;
    a_valid = 0; b_valid = 0; a_payload = 0; b_payload = 0; o_ready = 1; cur_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_o_payload", o_payload, 0);
    chk("rst_o_flags", o_flags, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    a_payload = 32'h40000000; b_payload = 32'h40400000; cur_exp = {32'h40C00000, 4'b0000};
    a_valid = 1; b_valid = 1;
    @(negedge clk);
    chk("join_ready", {a_ready, b_ready}, 2'b11);
    @(posedge clk);
    #1;
    idle();
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) send(tbl[i].a, tbl[i].b, {tbl[i].p, tbl[i].f});
    idle();
    repeat (6) @(posedge clk);
    #1;
    chk("table_drained", sb.size(), 0);
    n0 = nfire;
    a_valid = 1;
    a_payload = 32'h3F800000;
    repeat (4) begin
      @(negedge clk);
      chk("lone_a_ready", a_ready, 0);
    end
    chk("lone_no_fire", nfire - n0, 0);
    chk("lone_busy", busy, 0);
    idle();
    @(posedge clk);
    #1;
    o_ready = 0;
    n0 = nfire;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          x = rnd_op();
          y = rnd_op();
          send(x, y, model(x, y));
        end
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_fired", nfire - n0, 3);
        chk("bp_a_ready", a_ready, 0);
        chk("bp_o_valid", o_valid, 1);
        chk("bp_head", {o_payload, o_flags}, sb[0]);
        o_ready = 1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("bp_drained", sb.size(), 0);
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          x = rnd_op();
          y = rnd_op();
          send(x, y, model(x, y));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          o_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    o_ready = 1;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rand_drained", sb.size(), 0);
    chk("rand_busy", busy, 0);
    o_ready = 0;
    for (int i = 0; i < 3; i++) begin
      x = rnd_op();
      y = rnd_op();
      send(x, y, model(x, y));
    end
    chk("pre_rst_valid", o_valid, 1);
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_o_valid", o_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_payload", o_payload, 0);
    idle();
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1;
    o_ready = 1;
    @(posedge clk);
    #1;
    send(32'h40000000, 32'h40400000, {32'h40C00000, 4'b0000});
    idle();
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_drained", sb.size(), 0);
    chk("post_rst_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
